adv_timing_gen: RTL and testbench

Parametrised HDMI video timing and test-pattern generator that drives the ADV7513 video inputs (ADV_DE, ADV_Hsync, ADV_Vsync, ADV_D) from the fabric clock. It is controlled by the HPS over the AXI register port. It replaces hard-wired single-mode timing with generic horizontal/vertical timing, selectable sync polarity, three pattern modes, hot-plug gating, and readable frame and position status. The default parameters give 800x600@72 Hz, whose pixel clock is exactly 50 MHz.

---
 rtl/adv_video_pkg.sv | 48 ++++
 rtl/adv_sync_counter.sv | 88 ++++++++
 rtl/adv_timing_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_adv_timing_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adv_video_pkg.sv
// Shared definitions for the ADV7513 timing/pattern generator.
//   - register indices as decoded from AXI_Address[3:2]
//   - CTRL.MODE encoding
//   - colour-bar palette and a lookup helper
//   - 11-bit counter type shared by the counter sub-module and the top
package adv_video_pkg;

  localparam int CNT_W = 11;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COLOR  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_POS    = 2'd3;

  localparam logic [1:0] MODE_SOLID     = 2'd0;
  localparam logic [1:0] MODE_BARS      = 2'd1;
  localparam logic [1:0] MODE_GRADIENT  = 2'd2;
  localparam logic [1:0] MODE_SOLID_ALT = 2'd3;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Bar 0 is the leftmost bar.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/adv_sync_counter.sv
// Horizontal/vertical raster counters with sync and active-area decode.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - run enable; while low both counters are forced to 0
//   h_cnt       - pixel position in the line, 0..H_TOTAL-1
//   v_cnt       - line position in the frame, 0..V_TOTAL-1
//   active      - current position is inside the visible area
//   hs, vs      - sync intervals (active-high, polarity applied by the top)
//   frame_end   - last pixel of the last line while enabled
module adv_sync_counter
  import adv_video_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs,
  output logic             vs,
  output logic             frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_total_check
    $error("adv_sync_counter: timing total does not fit the 11-bit counters");
  end

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t h_reg, h_next;
  cnt_t v_reg, v_next;
  logic h_last, v_last;

  assign h_last = (h_reg == H_LAST);
  assign v_last = (v_reg == V_LAST);

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (!en) begin
      h_next = '0;
      v_next = '0;
    end else if (h_last) begin
      h_next = '0;
      v_next = v_last ? '0 : v_reg + cnt_t'(1);
    end else begin
      h_next = h_reg + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg <= '0;
      v_reg <= '0;
    end else begin
      h_reg <= h_next;
      v_reg <= v_next;
    end
  end

  assign h_cnt     = h_reg;
  assign v_cnt     = v_reg;
  assign active    = (h_reg < H_ACT) && (v_reg < V_ACT);
  assign hs        = (h_reg >= HS_START) && (h_reg < HS_END);
  // vsync follows whole lines, so it only depends on the line counter.
  assign vs        = (v_reg >= VS_START) && (v_reg < VS_END);
  assign frame_end = en && h_last && v_last;

endmodule

// File: rtl/adv_timing_gen.sv
// HDMI video timing and test-pattern generator for the ADV7513 inputs.
// Ports:
//   FPGA_CLK1_50   - pixel/system clock
//   FPGA_RST_N     - asynchronous active-low reset
//   AXI_Address    - byte address, bits [3:2] select CTRL/COLOR/STATUS/POS
//   AXI_Read/Write - single-cycle strobes; AXI_ReadData is registered
//   ADV_HPD        - hot-plug detect from the transmitter (asynchronous)
//   ADV_DE/Hsync/Vsync/D - registered video outputs, mutually aligned
module adv_timing_gen
  import adv_video_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        FPGA_CLK1_50,
  input  logic        FPGA_RST_N,
  input  logic [18:0] AXI_Address,
  input  logic        AXI_Read,
  input  logic        AXI_Write,
  input  logic [31:0] AXI_WriteData,
  output logic [31:0] AXI_ReadData,
  input  logic        ADV_HPD,
  output logic        ADV_DE,
  output logic        ADV_Hsync,
  output logic        ADV_Vsync,
  output logic [23:0] ADV_D
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   BAR_W    = H_ACTIVE / 8;
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t BAR_LAST = cnt_t'(BAR_W - 1);

  if (BAR_W < 1) begin : g_bar_check
    $error("adv_timing_gen: H_ACTIVE must be at least 8 for the colour bars");
  end

  // Address and data bits outside the decoded fields.
  logic bus_unused;
  assign bus_unused = ^{AXI_Address[18:4], AXI_Address[1:0], AXI_WriteData[31:24]};

  // ---------------------------------------------------------------- registers
  logic        ctrl_en_reg;
  logic [1:0]  ctrl_mode_reg;
  logic [23:0] color_reg;
  logic [15:0] frame_cnt_reg;
  logic [31:0] read_data_reg;
  logic [31:0] read_mux;
  logic [1:0]  reg_sel;

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             cnt_active;
  logic             cnt_hs;
  logic             cnt_vs;
  logic             frame_end;

  adv_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync_counter (
    .clk       (FPGA_CLK1_50),
    .rst_n     (FPGA_RST_N),
    .en        (ctrl_en_reg),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (cnt_active),
    .hs        (cnt_hs),
    .vs        (cnt_vs),
    .frame_end (frame_end)
  );

  // ------------------------------------------------------------ HPD sync
  logic hpd_meta_reg;
  logic hpd_sync_reg;

  always_ff @(posedge FPGA_CLK1_50 or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      hpd_meta_reg <= 1'b0;
      hpd_sync_reg <= 1'b0;
    end else begin
      hpd_meta_reg <= ADV_HPD;
      hpd_sync_reg <= hpd_meta_reg;
    end
  end

  // ------------------------------------------------------------ register file
  assign reg_sel = AXI_Address[3:2];

  always_comb begin
    read_mux = '0;
    unique case (reg_sel)
      REG_CTRL:   read_mux = {29'd0, ctrl_mode_reg, ctrl_en_reg};
      REG_COLOR:  read_mux = {8'd0, color_reg};
      REG_STATUS: read_mux = {frame_cnt_reg, 14'd0, cnt_active, hpd_sync_reg};
      REG_POS:    read_mux = {5'd0, v_cnt, 5'd0, h_cnt};
    endcase
  end

  // The read mux sees the pre-write register values, so a read and a
  // write to the same address in one cycle returns the old contents.
  always_ff @(posedge FPGA_CLK1_50 or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      ctrl_en_reg   <= 1'b0;
      ctrl_mode_reg <= MODE_SOLID;
      color_reg     <= '0;
      read_data_reg <= '0;
      frame_cnt_reg <= '0;
    end else begin
      if (AXI_Write) begin
        if (reg_sel == REG_CTRL) begin
          ctrl_en_reg   <= AXI_WriteData[0];
          ctrl_mode_reg <= AXI_WriteData[2:1];
        end
        if (reg_sel == REG_COLOR) begin
          color_reg <= AXI_WriteData[23:0];
        end
      end
      if (AXI_Read) begin
        read_data_reg <= read_mux;
      end
      if (frame_end) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign AXI_ReadData = read_data_reg;

  // ---------------------------------------------------------- bar index
  // Tracks h_cnt in parallel: restarts whenever h_cnt restarts, advances the
  // bar index every BAR_W pixels and parks on the last (black) bar, which
  // therefore also absorbs the H_ACTIVE % 8 remainder pixels.
  logic [2:0] bar_idx_reg, bar_idx_next;
  cnt_t       bar_pix_reg, bar_pix_next;

  always_comb begin
    bar_idx_next = bar_idx_reg;
    bar_pix_next = bar_pix_reg;
    if (!ctrl_en_reg || h_cnt == H_LAST) begin
      bar_idx_next = '0;
      bar_pix_next = '0;
    end else if (bar_pix_reg == BAR_LAST) begin
      bar_pix_next = '0;
      if (bar_idx_reg != 3'd7) begin
        bar_idx_next = bar_idx_reg + 3'd1;
      end
    end else begin
      bar_pix_next = bar_pix_reg + cnt_t'(1);
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      bar_idx_reg <= '0;
      bar_pix_reg <= '0;
    end else begin
      bar_idx_reg <= bar_idx_next;
      bar_pix_reg <= bar_pix_next;
    end
  end

  // ---------------------------------------------------------- pattern mux
  logic [23:0] pixel;
  logic [7:0]  grad_b;
  logic        show;

  assign grad_b = h_cnt[7:0] + v_cnt[7:0];

  always_comb begin
    pixel = color_reg;
    unique case (ctrl_mode_reg)
      MODE_SOLID:     pixel = color_reg;
      MODE_BARS:      pixel = bar_color(bar_idx_reg);
      MODE_GRADIENT:  pixel = {h_cnt[7:0], v_cnt[7:0], grad_b};
      MODE_SOLID_ALT: pixel = color_reg;
    endcase
  end

  assign show = ctrl_en_reg && cnt_active && hpd_sync_reg;

  // ---------------------------------------------------------- output stage
  logic        de_reg;
  logic        hsync_reg;
  logic        vsync_reg;
  logic [23:0] d_reg;

  always_ff @(posedge FPGA_CLK1_50 or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      de_reg    <= 1'b0;
      hsync_reg <= !HS_POL;
      vsync_reg <= !VS_POL;
      d_reg     <= '0;
    end else begin
      de_reg    <= show;
      d_reg     <= show ? pixel : 24'd0;
      hsync_reg <= (ctrl_en_reg && cnt_hs) ? HS_POL : !HS_POL;
      vsync_reg <= (ctrl_en_reg && cnt_vs) ? VS_POL : !VS_POL;
    end
  end

  assign ADV_DE    = de_reg;
  assign ADV_Hsync = hsync_reg;
  assign ADV_Vsync = vsync_reg;
  assign ADV_D     = d_reg;

endmodule

// File: tb/tb_adv_timing_gen.sv
// Directed bench for adv_timing_gen using a reduced raster:
//   H: 20 active + 2 fp + 3 sync + 3 bp = 28 clocks per line
//   V:  4 active + 1 fp + 2 sync + 1 bp =  8 lines per frame (224 clocks)
//   HS_POL = 1, VS_POL = 0, bar width 2 with 4 remainder pixels.
// Capture index i holds the outputs produced from counter step i, where
// step 0 is the first cycle after the CTRL write that sets EN.
module tb_adv_timing_gen;

  localparam int H_A = 20, H_F = 2, H_S = 3, H_B = 3;
  localparam int V_A = 4,  V_F = 1, V_S = 2, V_B = 1;

  localparam logic [18:0] A_CTRL   = 19'h0;
  localparam logic [18:0] A_COLOR  = 19'h4;
  localparam logic [18:0] A_STATUS = 19'h8;
  localparam logic [18:0] A_POS    = 19'hC;

  localparam logic [23:0] BAR_EXP [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hpd = 1'b0;
  logic        de, hs, vs;
  logic [23:0] d;

  int checks = 0;
  int errors = 0;

  logic        cap_de [256];
  logic        cap_hs [256];
  logic        cap_vs [256];
  logic [23:0] cap_d  [256];

  always #5 clk = ~clk;

  adv_timing_gen #(
    .H_ACTIVE (H_A), .H_FP (H_F), .H_SYNC (H_S), .H_BP (H_B),
    .V_ACTIVE (V_A), .V_FP (V_F), .V_SYNC (V_S), .V_BP (V_B),
    .HS_POL   (1'b1), .VS_POL (1'b0)
  ) dut (
    .FPGA_CLK1_50  (clk),
    .FPGA_RST_N    (rst_n),
    .AXI_Address   (addr),
    .AXI_Read      (rd),
    .AXI_Write     (wr),
    .AXI_WriteData (wdata),
    .AXI_ReadData  (rdata),
    .ADV_HPD       (hpd),
    .ADV_DE        (de),
    .ADV_Hsync     (hs),
    .ADV_Vsync     (vs),
    .ADV_D         (d)
  );

  // All bus tasks start and end on a falling edge.
  task automatic reg_write(input logic [18:0] a, input logic [31:0] v);
    addr = a; wdata = v; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    $display("write addr=%h data=%h", a, v);
  endtask

  task automatic reg_read(input logic [18:0] a, output logic [31:0] v);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    v = rdata;
    $display("read  addr=%h data=%h", a, v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic capture(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      @(negedge clk);
      cap_de[i] = de; cap_hs[i] = hs; cap_vs[i] = vs; cap_d[i] = d;
    end
  endtask

  task automatic restart(input logic [31:0] ctrl);
    reg_write(A_CTRL, 32'h0);
    reg_write(A_CTRL, ctrl);
  endtask

  task automatic test_reset;
    idle(3);
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", de); end
    checks++; if (d !== 24'h0) begin errors++; $display("FAIL reset_d got %h want 000000", d); end
    checks++; if (hs !== 1'b0) begin errors++; $display("FAIL reset_hsync got %b want 0", hs); end
    checks++; if (vs !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vs); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    rst_n = 1'b1;
    idle(2);
    $display("reset released");
  endtask

  task automatic test_registers;
    logic [31:0] v;
    reg_read(A_CTRL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL ctrl_reset got %h want 00000000", v); end
    reg_read(A_COLOR, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL color_reset got %h want 00000000", v); end
    reg_write(A_COLOR, 32'hAB123456);
    reg_read(A_COLOR, v);
    checks++; if (v !== 32'h00123456) begin errors++; $display("FAIL color_rw got %h want 00123456", v); end
    // read and write to the same register in one cycle returns the old value
    addr = A_COLOR; wdata = 32'h00654321; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    $display("read+write addr=%h data=%h", A_COLOR, rdata);
    checks++; if (rdata !== 32'h00123456) begin errors++; $display("FAIL rw_same got %h want 00123456", rdata); end
    reg_read(A_COLOR, v);
    checks++; if (v !== 32'h00654321) begin errors++; $display("FAIL rw_after got %h want 00654321", v); end
    reg_write(A_STATUS, 32'hFFFFFFFF);
    reg_read(A_STATUS, v);
    checks++; if ((v & 32'hFFFFFFFD) !== 32'h0) begin errors++; $display("FAIL status_ro got %h want 0000000x", v); end
    reg_write(A_CTRL, 32'hFFFFFFF8);
    reg_read(A_CTRL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL ctrl_unused got %h want 00000000", v); end
    reg_read(A_POS, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL pos_idle got %h want 00000000", v); end
  endtask

  task automatic test_solid;
    int ones;
    int bad_d;
    hpd = 1'b1;
    idle(4);
    reg_write(A_COLOR, 32'h0000FF00);
    reg_write(A_CTRL, 32'h1);
    capture(0, 230);
    ones = 0; bad_d = 0;
    for (int i = 0; i < 224; i++) begin
      if (cap_de[i]) ones++;
      if (cap_d[i] !== (cap_de[i] ? 24'h00FF00 : 24'h000000)) bad_d++;
    end
    $display("solid: DE count %0d, bad D samples %0d", ones, bad_d);
    checks++; if (cap_de[0] !== 1'b1) begin errors++; $display("FAIL solid_de_first got %b want 1", cap_de[0]); end
    checks++; if (cap_de[19] !== 1'b1) begin errors++; $display("FAIL solid_de_last got %b want 1", cap_de[19]); end
    checks++; if (cap_de[20] !== 1'b0) begin errors++; $display("FAIL solid_de_end got %b want 0", cap_de[20]); end
    checks++; if (cap_hs[21] !== 1'b0) begin errors++; $display("FAIL solid_hs_pre got %b want 0", cap_hs[21]); end
    checks++; if (cap_hs[22] !== 1'b1) begin errors++; $display("FAIL solid_hs_start got %b want 1", cap_hs[22]); end
    checks++; if (cap_hs[24] !== 1'b1) begin errors++; $display("FAIL solid_hs_width got %b want 1", cap_hs[24]); end
    checks++; if (cap_hs[25] !== 1'b0) begin errors++; $display("FAIL solid_hs_end got %b want 0", cap_hs[25]); end
    checks++; if (cap_de[28] !== 1'b1) begin errors++; $display("FAIL solid_line_period got %b want 1", cap_de[28]); end
    checks++; if (cap_de[112] !== 1'b0) begin errors++; $display("FAIL solid_vblank got %b want 0", cap_de[112]); end
    checks++; if (cap_vs[139] !== 1'b1) begin errors++; $display("FAIL solid_vs_pre got %b want 1", cap_vs[139]); end
    checks++; if (cap_vs[140] !== 1'b0) begin errors++; $display("FAIL solid_vs_start got %b want 0", cap_vs[140]); end
    checks++; if (cap_vs[195] !== 1'b0) begin errors++; $display("FAIL solid_vs_last got %b want 0", cap_vs[195]); end
    checks++; if (cap_vs[196] !== 1'b1) begin errors++; $display("FAIL solid_vs_end got %b want 1", cap_vs[196]); end
    checks++; if (cap_de[223] !== 1'b0) begin errors++; $display("FAIL solid_frame_tail got %b want 0", cap_de[223]); end
    checks++; if (cap_de[224] !== 1'b1) begin errors++; $display("FAIL solid_frame_period got %b want 1", cap_de[224]); end
    checks++; if (ones != 80) begin errors++; $display("FAIL solid_de_count got %0d want 80", ones); end
    checks++; if (bad_d != 0) begin errors++; $display("FAIL solid_d got %0d bad samples want 0", bad_d); end
  endtask

  task automatic test_bars;
    logic [23:0] exp_c;
    restart(32'h3);
    capture(0, 28);
    for (int i = 0; i < 20; i++) begin
      exp_c = BAR_EXP[(i < 16) ? i / 2 : 7];
      checks++; if (cap_d[i] !== exp_c) begin errors++; $display("FAIL bars_px%0d got %h want %h", i, cap_d[i], exp_c); end
    end
    $display("bars: px0=%h px15=%h px19=%h", cap_d[0], cap_d[15], cap_d[19]);
    checks++; if (cap_d[20] !== 24'h0) begin errors++; $display("FAIL bars_blank got %h want 000000", cap_d[20]); end
  endtask

  task automatic test_gradient;
    restart(32'h5);
    capture(0, 104);
    $display("gradient: (0,0)=%h (10,2)=%h (19,3)=%h", cap_d[0], cap_d[66], cap_d[103]);
    checks++; if (cap_d[0] !== 24'h000000) begin errors++; $display("FAIL grad_0_0 got %h want 000000", cap_d[0]); end
    checks++; if (cap_d[66] !== 24'h0A020C) begin errors++; $display("FAIL grad_10_2 got %h want 0A020C", cap_d[66]); end
    checks++; if (cap_d[103] !== 24'h130316) begin errors++; $display("FAIL grad_19_3 got %h want 130316", cap_d[103]); end
    restart(32'h7);
    capture(0, 2);
    $display("mode3: px0=%h", cap_d[0]);
    checks++; if (cap_d[0] !== 24'h00FF00) begin errors++; $display("FAIL mode3_solid got %h want 00FF00", cap_d[0]); end
  endtask

  task automatic test_hpd;
    restart(32'h1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cap_de[i] = de; cap_hs[i] = hs; cap_vs[i] = vs; cap_d[i] = d;
      if (i == 3) hpd = 1'b0;
      if (i == 30) hpd = 1'b1;
    end
    $display("hpd: de[5]=%b de[6]=%b de[32]=%b de[33]=%b", cap_de[5], cap_de[6], cap_de[32], cap_de[33]);
    checks++; if (cap_de[5] !== 1'b1) begin errors++; $display("FAIL hpd_de_before got %b want 1", cap_de[5]); end
    checks++; if (cap_de[6] !== 1'b0) begin errors++; $display("FAIL hpd_de_drop got %b want 0", cap_de[6]); end
    checks++; if (cap_d[6] !== 24'h0) begin errors++; $display("FAIL hpd_d_drop got %h want 000000", cap_d[6]); end
    checks++; if (cap_hs[22] !== 1'b1) begin errors++; $display("FAIL hpd_hs_line0 got %b want 1", cap_hs[22]); end
    checks++; if (cap_hs[49] !== 1'b0) begin errors++; $display("FAIL hpd_hs_pre1 got %b want 0", cap_hs[49]); end
    checks++; if (cap_hs[50] !== 1'b1) begin errors++; $display("FAIL hpd_hs_line1 got %b want 1", cap_hs[50]); end
    checks++; if (cap_de[32] !== 1'b0) begin errors++; $display("FAIL hpd_de_still_off got %b want 0", cap_de[32]); end
    checks++; if (cap_de[33] !== 1'b1) begin errors++; $display("FAIL hpd_de_resume got %b want 1", cap_de[33]); end
    checks++; if (cap_d[33] !== 24'h00FF00) begin errors++; $display("FAIL hpd_d_resume got %h want 00FF00", cap_d[33]); end
  endtask

  task automatic test_status;
    logic [31:0] v;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    $display("reset pulse");
    reg_write(A_CTRL, 32'h1);
    idle(450);
    addr = A_STATUS; rd = 1'b1;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL status_not_yet got %h want 00000000", rdata); end
    @(negedge clk);
    rd = 1'b0;
    $display("read  addr=%h data=%h", A_STATUS, rdata);
    checks++; if (rdata !== 32'h00020003) begin errors++; $display("FAIL status_frames got %h want 00020003", rdata); end
    idle(3);
    checks++; if (rdata !== 32'h00020003) begin errors++; $display("FAIL status_hold got %h want 00020003", rdata); end
    reg_read(A_POS, v);
    checks++; if (v !== 32'h00000006) begin errors++; $display("FAIL pos_first got %h want 00000006", v); end
    reg_read(A_POS, v);
    checks++; if (v !== 32'h00000007) begin errors++; $display("FAIL pos_second got %h want 00000007", v); end
  endtask

  task automatic test_en_clear;
    logic [31:0] v;
    idle(4);
    reg_write(A_CTRL, 32'h0);
    idle(1);
    $display("en cleared: de=%b hs=%b vs=%b d=%h", de, hs, vs, d);
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL enclr_de got %b want 0", de); end
    checks++; if (d !== 24'h0) begin errors++; $display("FAIL enclr_d got %h want 000000", d); end
    checks++; if (hs !== 1'b0) begin errors++; $display("FAIL enclr_hs got %b want 0", hs); end
    checks++; if (vs !== 1'b1) begin errors++; $display("FAIL enclr_vs got %b want 1", vs); end
    reg_read(A_POS, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL enclr_pos got %h want 00000000", v); end
    reg_read(A_STATUS, v);
    checks++; if (v[31:16] !== 16'd2) begin errors++; $display("FAIL enclr_frames got %0d want 2", v[31:16]); end
    reg_write(A_CTRL, 32'h1);
    capture(0, 24);
    checks++; if (cap_de[0] !== 1'b1) begin errors++; $display("FAIL reen_de got %b want 1", cap_de[0]); end
    checks++; if (cap_hs[21] !== 1'b0) begin errors++; $display("FAIL reen_hs_pre got %b want 0", cap_hs[21]); end
    checks++; if (cap_hs[22] !== 1'b1) begin errors++; $display("FAIL reen_hs_start got %b want 1", cap_hs[22]); end
  endtask

  task automatic test_reset_mid;
    capture(24, 140);
    checks++; if (cap_hs[163] !== 1'b1) begin errors++; $display("FAIL mid_hs_pre got %b want 1", cap_hs[163]); end
    checks++; if (cap_vs[163] !== 1'b0) begin errors++; $display("FAIL mid_vs_pre got %b want 0", cap_vs[163]); end
    rst_n = 1'b0;
    #1;
    $display("async reset: rdata=%h de=%b hs=%b vs=%b d=%h", rdata, de, hs, vs, d);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata got %h want 00000000", rdata); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL mid_de got %b want 0", de); end
    checks++; if (d !== 24'h0) begin errors++; $display("FAIL mid_d got %h want 000000", d); end
    checks++; if (hs !== 1'b0) begin errors++; $display("FAIL mid_hs got %b want 0", hs); end
    checks++; if (vs !== 1'b1) begin errors++; $display("FAIL mid_vs got %b want 1", vs); end
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_registers();
    test_solid();
    test_bars();
    test_gradient();
    test_hpd();
    test_status();
    test_en_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
